// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM requesters.
// Optional feature: define MEM_ARB_RDREG_EN to register the read-return path (read latency 2).
module onchip_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int DEPTH  = 15000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              err_clr,
  output logic              oor_err
);

  // One in-flight read return: who issued it and whether it hit the unpopulated region.
  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } ret_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              req0, req1, gnt0, gnt1, grant, last_grant;
  logic              sel_read, sel_write, in_range, rd_accept, oor_accept;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  ret_t              p1;
  logic [DATA_W-1:0] ret_data, rd0_q, rd1_q;
  logic              rdv0, rdv1;

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    req0        = m0_read | m0_write;
    req1        = m1_read | m1_write;
    gnt0        = reset_n & req0 & (~req1 | last_grant);
    gnt1        = reset_n & req1 & (~req0 | ~last_grant);
    grant       = gnt0 | gnt1;
    sel_address = '0;
    sel_be      = '0;
    sel_wdata   = '0;
    sel_read    = 1'b0;
    sel_write   = 1'b0;
    if (gnt1) begin
      sel_address = m1_address;
      sel_be      = m1_byteenable;
      sel_wdata   = m1_writedata;
      sel_read    = m1_read;
      sel_write   = m1_write;
    end else if (gnt0) begin
      sel_address = m0_address;
      sel_be      = m0_byteenable;
      sel_wdata   = m0_writedata;
      sel_read    = m0_read;
      sel_write   = m0_write;
    end
    in_range   = {1'b0, sel_address} < DEPTH_L;
    // Read+write together is a write; only a pure read expects a return.
    rd_accept  = grant & sel_read & ~sel_write;
    oor_accept = grant & ~in_range;
  end

  assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);
  assign mem_address    = sel_address;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  assign mem_chipselect = grant & in_range;
  assign mem_write      = grant & sel_write & in_range;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      oor_err    <= 1'b0;
      p1         <= '0;
    end else begin
      if (grant) last_grant <= gnt1;
      if (oor_accept)   oor_err <= 1'b1;
      else if (err_clr) oor_err <= 1'b0;
      p1 <= '{valid: rd_accept, owner: gnt1, oor: oor_accept};
    end
  end

  assign ret_data = p1.oor ? '0 : mem_readdata;
  assign rdv0     = p1.valid & ~p1.owner;
  assign rdv1     = p1.valid &  p1.owner;

`ifdef MEM_ARB_RDREG_EN
  logic rdv0_q, rdv1_q;

  // NOTE: the readdata holding registers are few and visible, so they take the reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv0_q <= 1'b0;
      rdv1_q <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      rdv0_q <= rdv0;
      rdv1_q <= rdv1;
      if (rdv0) rd0_q <= ret_data;
      if (rdv1) rd1_q <= ret_data;
    end
  end

  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;
  // Keep the RAM enabled one extra cycle so its output survives into the return register.
  assign mem_clken        = grant | p1.valid;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (rdv0) rd0_q <= ret_data;
      if (rdv1) rd1_q <= ret_data;
    end
  end

  // Owner sees RAM data directly on the return cycle; otherwise it keeps its last value.
  assign m0_readdatavalid = rdv0;
  assign m1_readdatavalid = rdv1;
  assign m0_readdata      = rdv0 ? ret_data : rd0_q;
  assign m1_readdata      = rdv1 ? ret_data : rd1_q;
  assign mem_clken        = grant;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model (grant rule, memory image, return queue).
module tb_onchip_mem_arbiter;

`ifdef MEM_ARB_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 15000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_clr, oor_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_clr(err_clr), .oor_err(oor_err)
  );

  // Environment: single-port RAM with one cycle of read latency.
  logic [31:0] ram [0:16383];
  logic [31:0] ram_q = '0;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_q <= ram[mem_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } ret_item_t;

  logic [31:0] ref_mem [0:16383];
  ret_item_t   pend[$];
  int          m_last = 1;
  bit          m_oor = 1'b0;
  bit          m_prev_rd = 1'b0;
  logic [31:0] m_last_rd [2] = '{32'h0, 32'h0};
  int          cyc = 0;

  initial for (int i = 0; i < 16384; i++) begin ram[i] = '0; ref_mem[i] = '0; end

  always @(negedge clk) begin
    int          g;
    bit          r0, r1, ev [2];
    logic [31:0] ed [2];
    logic [13:0] a;
    bit          rd, wr, inr;
    logic [3:0]  be;
    logic [31:0] d;
    #2;
    if (!reset_n) begin
      m_last = 1; pend.delete(); m_oor = 1'b0; m_prev_rd = 1'b0;
      m_last_rd[0] = '0; m_last_rd[1] = '0;
    end
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    g = -1;
    if (reset_n) begin
      if (r0 && r1) g = 1 - m_last;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
    end
    check("wait0", m0_waitrequest, !reset_n || (r0 && g != 0));
    check("wait1", m1_waitrequest, !reset_n || (r1 && g != 1));

    ev[0] = 0; ev[1] = 0;
    ed[0] = m_last_rd[0]; ed[1] = m_last_rd[1];
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev[pend[0].port] = 1;
      ed[pend[0].port] = pend[0].data;
      void'(pend.pop_front());
    end
    check("rdv0", m0_readdatavalid, ev[0]);
    check("rdv1", m1_readdatavalid, ev[1]);
    check("rdata0", m0_readdata, ed[0]);
    check("rdata1", m1_readdata, ed[1]);
    m_last_rd[0] = ed[0]; m_last_rd[1] = ed[1];
    check("oor_err", oor_err, m_oor);
    check("clken", mem_clken, reset_n && (g >= 0 || (LAT == 2 && m_prev_rd)));

    inr = 1'b0; rd = 1'b0; wr = 1'b0;
    if (g >= 0) begin
      a  = g ? m1_address : m0_address;
      rd = g ? m1_read : m0_read;
      wr = g ? m1_write : m0_write;
      be = g ? m1_byteenable : m0_byteenable;
      d  = g ? m1_writedata : m0_writedata;
      inr = int'(a) < DEPTH;
      check("mem_addr", mem_address, a);
      check("mem_cs", mem_chipselect, inr);
      check("mem_wr", mem_write, wr && inr);
      if (wr && inr) begin
        check("mem_be", mem_byteenable, be);
        check("mem_wdata", mem_writedata, d);
      end
      if (rd && !wr) pend.push_back('{due: cyc + LAT, port: g[0], data: inr ? ref_mem[a] : 32'h0});
      if (wr && inr)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      m_last = g;
    end else begin
      check("mem_cs_idle", mem_chipselect, 1'b0);
      check("mem_wr_idle", mem_write, 1'b0);
    end
    if (reset_n) begin
      if (g >= 0 && !inr) m_oor = 1'b1;
      else if (err_clr)   m_oor = 1'b0;
    end
    m_prev_rd = (g >= 0) && rd && !wr;
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic wait_of(input int p);
    return p ? m1_waitrequest : m0_waitrequest;
  endfunction
  function automatic logic valid_of(input int p);
    return p ? m1_readdatavalid : m0_readdatavalid;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return p ? m1_readdata : m0_readdata;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic do_access(input int p, input logic rd, input logic wr, input logic [13:0] a,
                           input logic [3:0] be, input logic [31:0] d, input logic clr,
                           output logic [31:0] rdata, output int lat);
    bit acc = 1'b0;
    rdata = '0;
    lat = 0;
    @(negedge clk);
    set_port(p, rd, wr, a, be, d);
    err_clr = clr;
    for (int i = 0; i < 16 && !acc; i++) begin
      #1;
      acc = !wait_of(p);
      @(negedge clk);
    end
    set_port(p, 1'b0, 1'b0, '0, '0, '0);
    err_clr = 1'b0;
    check("accept_timeout", acc, 1'b1);
    if (acc && rd && !wr) begin
      for (int k = 1; k <= 8 && lat == 0; k++) begin
        if (k > 1) @(negedge clk);
        #1;
        if (valid_of(p)) begin
          lat = k;
          rdata = rdata_of(p);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] rdata;
    int          lat;
    reset_n = 1'b0;
    err_clr = 1'b0;
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_wait0", m0_waitrequest, 1'b1);
    check("rst_wait1", m1_waitrequest, 1'b1);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("idle_wait0", m0_waitrequest, 1'b0);
    check("idle_wait1", m1_waitrequest, 1'b0);
    check("idle_clken", mem_clken, 1'b0);
    check("idle_cs", mem_chipselect, 1'b0);
    check("idle_addr", mem_address, 32'h0);
    check("idle_oor", oor_err, 1'b0);
    check("idle_rdata0", m0_readdata, 32'h0);

    // Reset asserted while a read is in flight: its return must never appear.
    @(negedge clk);
    set_port(0, 1, 0, 14'd5, 4'hF, '0);
    #1;
    check("rmr_accept", m0_waitrequest, 1'b0);
    @(negedge clk);
    set_port(0, 0, 0, '0, '0, '0);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rmr_no_rdv", m0_readdatavalid, 1'b0);
      @(negedge clk);
    end

    // Both ports saturating from the first cycle after reset: 0,1,0,1...
    reset_n = 1'b1;
    set_port(0, 1, 0, 14'h10, 4'hF, '0);
    set_port(1, 1, 0, 14'h11, 4'hF, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("sat_wait0", m0_waitrequest, i % 2);
      check("sat_wait1", m1_waitrequest, 1 - (i % 2));
      @(negedge clk);
    end
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);

    do_access(0, 0, 1, 14'h0010, 4'hF, 32'hDEADBEEF, 1'b0, rdata, lat);
    do_access(1, 1, 0, 14'h0010, 4'hF, '0, 1'b0, rdata, lat);
    check("wr_rd_data", rdata, 32'hDEADBEEF);
    check("wr_rd_lat", lat, LAT);

    do_access(0, 0, 1, 14'h0030, 4'hF, 32'hFFFFFFFF, 1'b0, rdata, lat);
    do_access(0, 0, 1, 14'h0030, 4'b0101, 32'h11223344, 1'b0, rdata, lat);
    do_access(1, 1, 0, 14'h0030, 4'hF, '0, 1'b0, rdata, lat);
    check("be_data", rdata, 32'hFF22FF44);

    #1;
    check("oor_before", oor_err, 1'b0);
    do_access(1, 0, 1, 14'd15000, 4'hF, 32'hA5A5A5A5, 1'b0, rdata, lat);
    #1;
    check("oor_set", oor_err, 1'b1);
    do_access(0, 1, 0, 14'd15000, 4'hF, '0, 1'b0, rdata, lat);
    check("oor_rd_data", rdata, 32'h0);
    check("oor_rd_lat", lat, LAT);
    do_access(0, 1, 0, 14'd14999, 4'hF, '0, 1'b0, rdata, lat);
    check("last_word_lat", lat, LAT);
    do_access(0, 0, 1, 14'd15001, 4'hF, 32'h1, 1'b1, rdata, lat);
    #1;
    check("oor_set_wins", oor_err, 1'b1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("oor_cleared", oor_err, 1'b0);

    do_access(0, 1, 1, 14'h0020, 4'hF, 32'h12345678, 1'b0, rdata, lat);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rw_no_rdv", m0_readdatavalid, 1'b0);
      @(negedge clk);
    end
    do_access(1, 1, 0, 14'h0020, 4'hF, '0, 1'b0, rdata, lat);
    check("rw_data", rdata, 32'h12345678);

    // Randomized traffic; the per-cycle model checks everything.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 499) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 2; p++) begin
        logic [13:0] a;
        int          sel, kind;
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = 14'($urandom_range(0, 31));
        else if (sel == 7) a = 14'd14999;
        else if (sel == 8) a = 14'($urandom_range(15000, 16383));
        else               a = 14'($urandom_range(14990, 14999));
        kind = $urandom_range(0, 7);
        set_port(p, kind inside {1, 2, 3, 6}, kind inside {4, 5, 6}, a,
                 4'($urandom_range(0, 15)), $urandom);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    err_clr = 1'b0;
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    repeat (5) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
